riscv_lsu: RTL and testbench

Multi-cycle load/store unit: the initiator side of the data-memory port. It takes one load or store request from the multi-cycle control FSM, checks alignment and range, and drives the data memory's word address, write strobe, byte enables and lane-replicated write data. For loads it captures the memory's synchronous read data and returns an extracted, sign- or zero-extended result. It sits between the core datapath/control and `RISCV_DMEM`.

---
 rtl/riscv_lsu_pkg.sv | 17 +
 rtl/riscv_lsu_align.sv | 28 ++
 rtl/riscv_lsu.sv | 111 +++++++++++
 tb/tb_riscv_lsu.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared funct3 codes, FSM states and defaults for the load/store unit
package riscv_lsu_pkg;
    localparam int DM_AW_DEF = 10;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} lsu_state_t;
    // Width codes with no RV32I meaning for the given direction
    function automatic logic illegal_f3(input logic st, input logic [2:0] f3);
        return st ? (f3 >= 3'b011) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte-enable generation, store lane replication and load extract/extend
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] sh;
    // Lanes for stores, right-justified and extended value for loads
    always_comb begin
        sh    = read_data >> {off, 3'b000};
        be    = funct3 == SB ? 4'b0001 << off :
                funct3 == SH ? 4'b0011 << {off[1], 1'b0} :
                funct3 == SW ? 4'b1111 : 4'b0000;
        wdata = funct3 == SB ? {4{store_data[7:0]}} :
                funct3 == SH ? {2{store_data[15:0]}} : store_data;
        rdata = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == LW  ? read_data :
                funct3 == LBU ? {24'h0, sh[7:0]} :
                funct3 == LHU ? {16'h0, sh[15:0]} : 32'h0;
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: multi-cycle load/store unit driving the data-memory port
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] eff_addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] addr,
    output logic        DMwr,
    output logic [3:0]  WRbe,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);
    lsu_state_t  state, next_state;
    logic        st_q, st_c, bad, accept;
    logic [2:0]  f3_q, f3_c;
    logic [31:0] ea_q, ea_c, sd_q, sd_c;
    logic [3:0]  be;
    logic [31:0] wdata, rdata;
    logic        busy_n, done_n, err_n, dmwr_n;
    logic [31:0] addr_n, wd_n;
    logic [3:0]  be_n;

    riscv_lsu_align u_align (
        .funct3     (f3_c),
        .off        (ea_c[1:0]),
        .store_data (sd_c),
        .read_data  (ReadData),
        .be         (be),
        .wdata      (wdata),
        .rdata      (rdata)
    );

    // Outputs are registered, so the accept cycle must look at the live inputs
    always_comb begin
        accept = state == IDLE && start;
        st_c   = state == IDLE ? is_store : st_q;
        f3_c   = state == IDLE ? funct3 : f3_q;
        ea_c   = state == IDLE ? eff_addr : ea_q;
        sd_c   = state == IDLE ? store_data : sd_q;
        bad    = illegal_f3(st_c, f3_c) || (|ea_c[31:DM_AW+2]) ||
                 (f3_c[1:0] == 2'b01 && ea_c[0]) || (f3_c[1:0] == 2'b10 && |ea_c[1:0]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; bad requests skip the memory access entirely
    always_comb begin
        next_state = state == IDLE    ? (start ? (bad ? DONE : ACCESS) : IDLE) :
                     state == ACCESS  ? (st_q ? DONE : CAPTURE) :
                     state == CAPTURE ? DONE : IDLE;
    end

    // Next values of the registered outputs, derived from the state being entered
    always_comb begin
        busy_n = next_state != IDLE;
        done_n = next_state == DONE;
        err_n  = accept && bad;
        dmwr_n = next_state == ACCESS && st_c;
        addr_n = next_state == ACCESS ? 32'(ea_c[DM_AW+1:2]) : 32'h0;
        be_n   = dmwr_n ? be : 4'b0000;
        wd_n   = dmwr_n ? wdata : 32'h0;
    end

    // Output registers, request latch and load result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            DMwr      <= 1'b0;
            addr      <= 32'h0;
            WRbe      <= 4'b0000;
            WriteData <= 32'h0;
            load_data <= 32'h0;
            st_q      <= 1'b0;
            f3_q      <= 3'b000;
            ea_q      <= 32'h0;
            sd_q      <= 32'h0;
        end else begin
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            DMwr      <= dmwr_n;
            addr      <= addr_n;
            WRbe      <= be_n;
            WriteData <= wd_n;
            if (state == CAPTURE) load_data <= rdata;
            if (accept) begin
                st_q <= is_store;
                f3_q <= funct3;
                ea_q <= eff_addr;
                sd_q <= store_data;
            end
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed checks of riscv_lsu against a behavioural data memory
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] eff_addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, err, DMwr;
    logic [31:0] load_data, addr, WriteData;
    logic [3:0]  WRbe;
    logic [31:0] ReadData = 32'h0;
    logic [31:0] mem [0:1023];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat, wcnt;
    logic        err_s, busy_ok;
    logic [31:0] ld_s, wd_s, wa_s;
    logic [3:0]  wbe_s;

    riscv_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .eff_addr   (eff_addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .addr       (addr),
        .DMwr       (DMwr),
        .WRbe       (WRbe),
        .WriteData  (WriteData),
        .ReadData   (ReadData)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 1024; i++) mem[i] = i * 10;

    always @(posedge clk) begin
        if (DMwr)
            for (int n = 0; n < 4; n++)
                if (WRbe[n]) mem[addr[9:0]][8*n +: 8] <= WriteData[8*n +: 8];
        ReadData <= mem[addr[9:0]];
    end

    // Issue one request from an IDLE-cycle negedge and watch it to completion
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] sd);
        is_store = st; funct3 = f3; eff_addr = ea; store_data = sd; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0; wcnt = 0; err_s = 1'b0; busy_ok = 1'b1; ld_s = 32'h0;
        wbe_s = 4'h0; wd_s = 32'h0; wa_s = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (DMwr) begin wcnt++; wbe_s = WRbe; wd_s = WriteData; wa_s = addr; end
            if (done) begin lat = c; err_s = err; ld_s = load_data; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if ({busy, done, err, DMwr} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl got %b need 0000", {busy, done, err, DMwr}); end
        n_cmp++; if ({load_data, addr, WriteData, WRbe} !== 100'h0) begin n_bad++; $display("FAIL reset_data got %h need 0", {load_data, addr, WriteData, WRbe}); end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_load_ext;
        run_req(1'b0, 3'b000, 32'h64, 32'h0);
        n_cmp++; if (ld_s !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL lb_data got %h need FFFFFFFA", ld_s); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lb_latency got %0d need 3", lat); end
        n_cmp++; if ({err_s, wcnt[0], busy_ok} !== 3'b001) begin n_bad++; $display("FAIL lb_flags got %b need 001", {err_s, wcnt[0], busy_ok}); end
        run_req(1'b0, 3'b100, 32'h64, 32'h0);
        n_cmp++; if (ld_s !== 32'h000000FA) begin n_bad++; $display("FAIL lbu_data got %h need 000000FA", ld_s); end
    endtask

    task automatic test_store_half;
        run_req(1'b1, 3'b001, 32'h12, 32'h1234ABCD);
        n_cmp++; if (wbe_s !== 4'b1100) begin n_bad++; $display("FAIL sh_wrbe got %b need 1100", wbe_s); end
        n_cmp++; if (wd_s !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata got %h need ABCDABCD", wd_s); end
        n_cmp++; if (wa_s !== 32'h4) begin n_bad++; $display("FAIL sh_addr got %h need 4", wa_s); end
        n_cmp++; if ({lat, wcnt, err_s} !== {32'd2, 32'd1, 1'b0}) begin n_bad++; $display("FAIL sh_timing got lat %0d writes %0d err %b need 2 1 0", lat, wcnt, err_s); end
        n_cmp++; if ({DMwr, WRbe, WriteData, addr} !== 69'h0) begin n_bad++; $display("FAIL sh_idle_port got %b %b %h %h need zeros", DMwr, WRbe, WriteData, addr); end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        n_cmp++; if (ld_s !== 32'hABCD0028) begin n_bad++; $display("FAIL lw_after_sh got %h need ABCD0028", ld_s); end
    endtask

    task automatic test_bad;
        run_req(1'b0, 3'b010, 32'h6, 32'h0);
        n_cmp++; if ({lat, err_s, wcnt} !== {32'd1, 1'b1, 32'd0}) begin n_bad++; $display("FAIL lw_misalign got lat %0d err %b writes %0d need 1 1 0", lat, err_s, wcnt); end
        n_cmp++; if (ld_s !== 32'hABCD0028) begin n_bad++; $display("FAIL lw_misalign_data got %h need ABCD0028", ld_s); end
        run_req(1'b1, 3'b000, 32'h1000, 32'h55);
        n_cmp++; if ({lat, err_s, wcnt} !== {32'd1, 1'b1, 32'd0}) begin n_bad++; $display("FAIL sb_range got lat %0d err %b writes %0d need 1 1 0", lat, err_s, wcnt); end
        n_cmp++; if (ld_s !== 32'hABCD0028) begin n_bad++; $display("FAIL sb_range_data got %h need ABCD0028", ld_s); end
        run_req(1'b0, 3'b011, 32'h0, 32'h0);
        n_cmp++; if ({lat, err_s} !== {32'd1, 1'b1}) begin n_bad++; $display("FAIL ld_f3_011 got lat %0d err %b need 1 1", lat, err_s); end
        run_req(1'b1, 3'b011, 32'h0, 32'h0);
        n_cmp++; if ({lat, err_s, wcnt} !== {32'd1, 1'b1, 32'd0}) begin n_bad++; $display("FAIL st_f3_011 got lat %0d err %b writes %0d need 1 1 0", lat, err_s, wcnt); end
    endtask

    task automatic test_half_loads;
        run_req(1'b0, 3'b101, 32'h0A, 32'h0);
        n_cmp++; if (ld_s !== 32'h0) begin n_bad++; $display("FAIL lhu_upper got %h need 00000000", ld_s); end
        run_req(1'b0, 3'b001, 32'h08, 32'h0);
        n_cmp++; if (ld_s !== 32'h14) begin n_bad++; $display("FAIL lh_lower got %h need 00000014", ld_s); end
    endtask

    task automatic test_store_byte;
        run_req(1'b1, 3'b000, 32'h31, 32'hCAFE0085);
        n_cmp++; if ({wbe_s, wd_s, wa_s} !== {4'b0010, 32'h85858585, 32'hC}) begin n_bad++; $display("FAIL sb_port got %b %h %h need 0010 85858585 0000000c", wbe_s, wd_s, wa_s); end
        run_req(1'b0, 3'b000, 32'h31, 32'h0);
        n_cmp++; if (ld_s !== 32'hFFFFFF85) begin n_bad++; $display("FAIL lb_after_sb got %h need FFFFFF85", ld_s); end
        run_req(1'b0, 3'b010, 32'h30, 32'h0);
        n_cmp++; if (ld_s !== 32'h00008578) begin n_bad++; $display("FAIL lw_after_sb got %h need 00008578", ld_s); end
    endtask

    task automatic test_reset_access;
        is_store = 1'b1; funct3 = 3'b010; eff_addr = 32'h20; store_data = 32'hDEADBEEF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_cmp++; if (DMwr !== 1'b1) begin n_bad++; $display("FAIL sw_access_dmwr got %b need 1", DMwr); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({DMwr, WRbe, busy} !== 6'b0) begin n_bad++; $display("FAIL async_reset got %b need 000000", {DMwr, WRbe, busy}); end
        @(posedge clk); @(negedge clk); rst_n = 1'b1; @(negedge clk);
        run_req(1'b0, 3'b010, 32'h20, 32'h0);
        n_cmp++; if (ld_s !== 32'h50) begin n_bad++; $display("FAIL lw_after_reset got %h need 00000050", ld_s); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp_busy, exp_done, exp_wr;
        exp_busy = 6'b111011;
        exp_done = 6'b100010;
        exp_wr   = 6'b000001;
        is_store = 1'b1; funct3 = 3'b010; eff_addr = 32'h40; store_data = 32'h11223344; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin is_store = 1'b0; store_data = 32'h0; end
            n_cmp++; if ({busy, done, DMwr} !== {exp_busy[c-1], exp_done[c-1], exp_wr[c-1]}) begin n_bad++; $display("FAIL b2b_cycle%0d got busy %b done %b dmwr %b need %b %b %b", c, busy, done, DMwr, exp_busy[c-1], exp_done[c-1], exp_wr[c-1]); end
            if (c == 6) begin
                start = 1'b0;
                n_cmp++; if (load_data !== 32'h11223344) begin n_bad++; $display("FAIL b2b_load got %h need 11223344", load_data); end
            end
        end
        @(negedge clk);
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle got %b need 00", {busy, done}); end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_half();
        test_bad();
        test_half_loads();
        test_store_byte();
        test_reset_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
